// File: rtl/piso_8_bit_tick_if.sv
// Load handshake and serial/display bus for piso_8_bit_tick.
// The master drives load/data; the slave (the shifter) returns status, the serial bit and the live register.
interface piso_8_bit_tick_if #(
    parameter int WIDTH = 8
);
    logic             load;
    logic [WIDTH-1:0] data;
    logic             ready;
    logic             serial_out;
    logic             done;
    logic [WIDTH-1:0] q;

    modport master (
        output load, data,
        input  ready, serial_out, done, q
    );

    modport slave (
        input  load, data,
        output ready, serial_out, done, q
    );
endinterface

// File: rtl/piso_8_bit_tick.sv
// Parallel-in, serial-out shifter, MSB first, one bit per TICK_DIV clocks.
// Define PISO_PARITY_EN to append one even-parity bit period after the data bits.
module piso_8_bit_tick #(
    parameter int TICK_DIV = 25_000_000,
    parameter int WIDTH    = 8
) (
    input  logic                clk,
    input  logic                reset,
    piso_8_bit_tick_if.slave    bus
);
    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int BIT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TICK_DIV - 1);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] tick_cnt_reg;
    logic [BIT_W-1:0] bit_cnt_reg;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;
    logic             serial_reg;
    logic             done_reg;
    logic             tick;
`ifdef PISO_PARITY_EN
    localparam logic [BIT_W-1:0] LAST_PAR = BIT_W'(WIDTH);
    logic             parity_reg;
`endif

    assign tick = (tick_cnt_reg == CNT_MAX);

    // Left shift with zero fill; bit 0 always receives a zero.
    assign shift_next[0] = 1'b0;
    genvar gi;
    generate
        for (gi = 1; gi < WIDTH; gi++) begin : g_shift
            assign shift_next[gi] = shift_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            tick_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            serial_reg   <= 1'b0;
            done_reg     <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_reg   <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    tick_cnt_reg <= '0;
                    serial_reg   <= 1'b0;
                    if (bus.load) begin
                        shift_reg   <= bus.data;
                        bit_cnt_reg <= '0;
                        serial_reg  <= bus.data[WIDTH-1];
                        state_reg   <= SHIFT;
`ifdef PISO_PARITY_EN
                        parity_reg  <= ^bus.data;
`endif
                    end
                end

                SHIFT: begin
                    tick_cnt_reg <= tick ? '0 : tick_cnt_reg + CNT_W'(1);
                    if (tick) begin
`ifdef PISO_PARITY_EN
                        if (bit_cnt_reg == LAST_PAR) begin
                            state_reg  <= IDLE;
                            done_reg   <= 1'b1;
                            serial_reg <= 1'b0;
                        end else if (bit_cnt_reg == LAST_DATA) begin
                            // Parity period: the display register is blanked.
                            shift_reg   <= '0;
                            serial_reg  <= parity_reg;
                            bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
                        end else begin
                            shift_reg   <= shift_next;
                            serial_reg  <= shift_next[WIDTH-1];
                            bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
                        end
`else
                        if (bit_cnt_reg == LAST_DATA) begin
                            state_reg  <= IDLE;
                            done_reg   <= 1'b1;
                            serial_reg <= 1'b0;
                        end else begin
                            shift_reg   <= shift_next;
                            serial_reg  <= shift_next[WIDTH-1];
                            bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
                        end
`endif
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

    // ready is the only output decoded (from state only) rather than held in its own flop.
    assign bus.ready      = (state_reg == IDLE);
    assign bus.serial_out = serial_reg;
    assign bus.done       = done_reg;
    assign bus.q          = shift_reg;

endmodule

// File: tb/tb_piso_8_bit_tick.sv
// Directed bench for piso_8_bit_tick with TICK_DIV=4; expected streams and parity are hand-written.
// Outputs are sampled on the falling edge; inputs are driven there too.
module tb_piso_8_bit_tick;
    localparam int TD = 4;
`ifdef PISO_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic clk;
    logic reset;
    int   vectors_applied = 0;
    int   miscompares     = 0;

    piso_8_bit_tick_if #(.WIDTH(8)) bus ();

    piso_8_bit_tick #(.TICK_DIV(TD), .WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors_applied++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clk_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Caller has already driven load/data for edge 0. Checks cycles 1..NB*TD and the done cycle.
    task automatic run_frame(input string name, input logic [7:0] first_data,
                             input logic [7:0] stream, input logic par,
                             input int pulse_at, input logic [7:0] pulse_data,
                             input bit keep_load);
        logic [7:0] exp_q;
        logic       exp_bit;
        int         idx;
        for (int c = 1; c <= NB * TD; c++) begin
            clk_cycle();
            idx = (c - 1) / TD;
            if (idx < 8) begin
                exp_bit = stream[7 - idx];
                exp_q   = first_data << idx;
            end else begin
                exp_bit = par;
                exp_q   = 8'h00;
            end
            check_val($sformatf("%s serial c%0d", name, c), 32'(bus.serial_out), 32'(exp_bit));
            check_val($sformatf("%s q c%0d", name, c), 32'(bus.q), 32'(exp_q));
            check_val($sformatf("%s ready c%0d", name, c), 32'(bus.ready), 32'd0);
            check_val($sformatf("%s done c%0d", name, c), 32'(bus.done), 32'd0);
            if (keep_load || c == pulse_at) begin
                bus.load = 1'b1;
                bus.data = pulse_data;
            end else begin
                bus.load = 1'b0;
            end
        end
        clk_cycle();
        check_val($sformatf("%s done pulse", name), 32'(bus.done), 32'd1);
        check_val($sformatf("%s ready at done", name), 32'(bus.ready), 32'd1);
        check_val($sformatf("%s serial at done", name), 32'(bus.serial_out), 32'd0);
        if (!keep_load) begin
            clk_cycle();
            check_val($sformatf("%s done cleared", name), 32'(bus.done), 32'd0);
            check_val($sformatf("%s ready idle", name), 32'(bus.ready), 32'd1);
        end
        $display("frame %s data=%02h sent, %0d miscompares so far", name, first_data, miscompares);
    endtask

    initial begin
        reset    = 1'b0;
        bus.load = 1'b0;
        bus.data = 8'h00;
        #1;
        check_val("reset serial", 32'(bus.serial_out), 32'd0);
        check_val("reset ready", 32'(bus.ready), 32'd1);
        check_val("reset done", 32'(bus.done), 32'd0);
        check_val("reset q", 32'(bus.q), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Idle hold: {serial, ready, done, q} stays {0,1,0,00}
        for (int c = 0; c < 50; c++) begin
            clk_cycle();
            check_val($sformatf("idle c%0d", c), {21'd0, bus.serial_out, bus.ready, bus.done, bus.q},
                      {21'd0, 1'b0, 1'b1, 1'b0, 8'h00});
        end
        $display("idle hold of 50 cycles done");

        // Single byte A5
        bus.load = 1'b1; bus.data = 8'hA5;
        run_frame("a5", 8'hA5, 8'b1010_0101, 1'b0, -1, 8'h00, 1'b0);

        // Busy rejection: 0F pulsed at cycle 10 must be ignored
        bus.load = 1'b1; bus.data = 8'hF0;
        run_frame("busy", 8'hF0, 8'b1111_0000, 1'b0, 10, 8'h0F, 1'b0);
        check_val("busy not resent", 32'(bus.ready), 32'd1);

        // Back-to-back: second frame accepted at done cycle
        bus.load = 1'b1; bus.data = 8'h81;
        run_frame("b2b1", 8'h81, 8'b1000_0001, 1'b0, -1, 8'h3C, 1'b1);
        run_frame("b2b2", 8'h3C, 8'b0011_1100, 1'b0, -1, 8'h00, 1'b0);

        // Mid-frame reset at cycle 13, between edges
        bus.load = 1'b1; bus.data = 8'hFF;
        clk_cycle();
        bus.load = 1'b0;
        for (int c = 2; c <= 13; c++) clk_cycle();
        check_val("pre-reset serial", 32'(bus.serial_out), 32'd1);
        #2 reset = 1'b0;
        #1;
        check_val("abort serial", 32'(bus.serial_out), 32'd0);
        check_val("abort q", 32'(bus.q), 32'd0);
        check_val("abort done", 32'(bus.done), 32'd0);
        check_val("abort ready", 32'(bus.ready), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            clk_cycle();
            check_val($sformatf("post-abort done c%0d", c), 32'(bus.done), 32'd0);
            check_val($sformatf("post-abort ready c%0d", c), 32'(bus.ready), 32'd1);
        end
        $display("mid-frame reset abort checked");
        bus.load = 1'b1; bus.data = 8'h01;
        run_frame("after_rst", 8'h01, 8'b0000_0001, 1'b1, -1, 8'h00, 1'b0);

        // 07: parity bit 1 when the parity option is built in
        bus.load = 1'b1; bus.data = 8'h07;
        run_frame("x07", 8'h07, 8'b0000_0111, 1'b1, -1, 8'h00, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end
endmodule
